// File: rtl/board_scan_pkg.sv
// Shared state encoding, default geometry and counter widths for the board scanner.
package board_scan_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2
  } scan_state_e;

  localparam int DEF_ROWS          = 8;
  localparam int DEF_COLS          = 8;
  localparam int DEF_SETTLE        = 1;
  localparam int DEF_STABLE_FRAMES = 2;

  // Wide enough for the largest legal SETTLE (15) and STABLE_FRAMES (7).
  localparam int SETTLE_W = 4;
  localparam int STABLE_W = 3;

`ifdef BOARD_SCANNER_CHANGE_MASK_EN
  localparam bit CHANGE_MASK_EN = 1'b1;
`else
  localparam bit CHANGE_MASK_EN = 1'b0;
`endif

endpackage

// File: rtl/scan_debouncer.sv
// Frame stability tracking and publish/overrun decision for the board scanner.
// Optional change_mask output when BOARD_SCANNER_CHANGE_MASK_EN is defined.
module scan_debouncer
  import board_scan_pkg::*;
#(
  parameter int WIDTH         = DEF_ROWS * DEF_COLS,
  parameter int STABLE_FRAMES = DEF_STABLE_FRAMES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_end,
  input  logic [WIDTH-1:0] frame,
  input  logic             layout_ready,
  output logic [WIDTH-1:0] layout,
  output logic             layout_valid,
  output logic             overrun
`ifdef BOARD_SCANNER_CHANGE_MASK_EN
  ,
  output logic [WIDTH-1:0] change_mask
`endif
);

  logic [WIDTH-1:0]    prev_frame;
  logic [STABLE_W-1:0] stable_cnt;
  logic [STABLE_W-1:0] stable_next;
  logic                first_pending;
  logic                publishable;
  logic                load;
  logic                drop;

  always_comb begin
    stable_next = STABLE_W'(1);
    if (frame == prev_frame) begin
      stable_next = stable_cnt;
      if (stable_cnt < STABLE_W'(STABLE_FRAMES)) begin
        stable_next = stable_cnt + 1'b1;
      end
    end
  end

  // A stable frame is only worth publishing if it differs from what the consumer already has.
  assign publishable = frame_end && (stable_next == STABLE_W'(STABLE_FRAMES)) &&
                       ((frame != layout) || first_pending);
  assign load        = publishable && (!layout_valid || layout_ready);
  assign drop        = publishable && layout_valid && !layout_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_frame <= '0;
      stable_cnt <= '0;
    end else if (frame_end) begin
      prev_frame <= frame;
      stable_cnt <= stable_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      layout        <= '0;
      layout_valid  <= 1'b0;
      first_pending <= 1'b1;
      overrun       <= 1'b0;
    end else begin
      overrun <= drop;
      if (load) begin
        layout        <= frame;
        layout_valid  <= 1'b1;
        first_pending <= 1'b0;
      end else if (layout_valid && layout_ready) begin
        layout_valid <= 1'b0;
      end
    end
  end

`ifdef BOARD_SCANNER_CHANGE_MASK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      change_mask <= '0;
    end else if (load) begin
      change_mask <= frame ^ layout;
    end
  end
`endif

endmodule

// File: rtl/board_scanner.sv
// Row-scanning keyboard/board matrix reader with debounced, handshaked frame publishing.
// Define BOARD_SCANNER_CHANGE_MASK_EN to add the change_mask output.
module board_scanner
  import board_scan_pkg::*;
#(
  parameter int ROWS          = DEF_ROWS,
  parameter int COLS          = DEF_COLS,
  parameter int SETTLE        = DEF_SETTLE,
  parameter int STABLE_FRAMES = DEF_STABLE_FRAMES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [COLS-1:0]      c,
  output logic [ROWS-1:0]      r,
  output logic [ROWS*COLS-1:0] layout,
  output logic                 layout_valid,
  input  logic                 layout_ready,
  output logic                 overrun
`ifdef BOARD_SCANNER_CHANGE_MASK_EN
  ,
  output logic [ROWS*COLS-1:0] change_mask
`endif
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  scan_state_e           state;
  scan_state_e           state_next;
  logic [RW-1:0]         row;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic                  settle_done;
  logic                  last_row;
  logic                  frame_end;
  logic [ROWS*COLS-1:0]  frame_now;

  assign settle_done = (settle_cnt == SETTLE_W'(SETTLE - 1));
  assign last_row    = (row == RW'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // enable is only looked at between frames, so a mid-frame drop still finishes the frame.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (enable) state_next = DRIVE;
      DRIVE:   if (settle_done) state_next = SAMPLE;
      SAMPLE:  state_next = (last_row && !enable) ? IDLE : DRIVE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    r         = '0;
    frame_end = 1'b0;
    if (state != IDLE) begin
      r[row] = 1'b1;
    end
    if (state == SAMPLE && last_row) begin
      frame_end = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      row        <= '0;
      settle_cnt <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          row        <= '0;
          settle_cnt <= '0;
        end
        DRIVE: begin
          settle_cnt <= settle_done ? '0 : settle_cnt + 1'b1;
        end
        SAMPLE: begin
          row        <= last_row ? '0 : row + 1'b1;
          settle_cnt <= '0;
        end
        default: begin
          row        <= '0;
          settle_cnt <= '0;
        end
      endcase
    end
  end

  // The debouncer sees the completed frame on the last SAMPLE cycle, with c standing in
  // for the row slot that is being written on that same edge.
  for (genvar g = 0; g < ROWS; g++) begin : g_row
    logic [COLS-1:0] raw_q;

    always_ff @(posedge clk) begin
      if (reset) begin
        raw_q <= '0;
      end else if (state == SAMPLE && row == RW'(g)) begin
        raw_q <= c;
      end
    end

    assign frame_now[(ROWS-g)*COLS-1 -: COLS] = (row == RW'(g)) ? c : raw_q;
  end

  scan_debouncer #(
    .WIDTH         (ROWS * COLS),
    .STABLE_FRAMES (STABLE_FRAMES)
  ) u_debouncer (
    .clk          (clk),
    .reset        (reset),
    .frame_end    (frame_end),
    .frame        (frame_now),
    .layout_ready (layout_ready),
    .layout       (layout),
    .layout_valid (layout_valid),
    .overrun      (overrun)
`ifdef BOARD_SCANNER_CHANGE_MASK_EN
    ,
    .change_mask  (change_mask)
`endif
  );

endmodule

// File: tb/tb_board_scanner.sv
// Self-checking bench for board_scanner (8x8, SETTLE=1, STABLE_FRAMES=2) against a frame-level model.
module tb_board_scanner;

  localparam int ROWS   = 8;
  localparam int COLS   = 8;
  localparam int SETTLE = 1;
  localparam int STABLE = 2;
  localparam int S1     = SETTLE + 1;
  localparam int FLEN   = ROWS * S1;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  c = 8'h00;
  logic [7:0]  r;
  logic [63:0] layout;
  logic        layout_valid;
  logic        layout_ready = 1'b0;
  logic        overrun;
`ifdef BOARD_SCANNER_CHANGE_MASK_EN
  logic [63:0] change_mask;
`endif

  int checks = 0;
  int errors = 0;

  board_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SETTLE(SETTLE), .STABLE_FRAMES(STABLE)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .c            (c),
    .r            (r),
    .layout       (layout),
    .layout_valid (layout_valid),
    .layout_ready (layout_ready),
    .overrun      (overrun)
`ifdef BOARD_SCANNER_CHANGE_MASK_EN
    ,
    .change_mask  (change_mask)
`endif
  );

  always #5 clk = ~clk;

  // Reference model: position within the frame plus frame-level debounce/publish rules.
  logic        m_run;
  int          m_pos;
  logic [7:0]  m_rows [ROWS];
  logic [63:0] m_prev, m_layout, m_mask;
  int          m_cnt;
  logic        m_valid, m_first, m_ov;
  int          m_frames;

  function automatic logic [7:0] row_of(input logic [63:0] b, input int k);
    logic [63:0] t;
    t = b >> ((ROWS - 1 - k) * COLS);
    return t[7:0];
  endfunction

  task automatic model_update(input logic en, input logic rst, input logic rdy, input logic [7:0] col);
    logic        fend;
    logic        pub;
    logic        ld;
    logic [63:0] f;
    fend = 1'b0;
    if (rst) begin
      m_run = 1'b0; m_pos = 0; m_prev = '0; m_layout = '0; m_mask = '0;
      m_cnt = 0; m_valid = 1'b0; m_first = 1'b1; m_ov = 1'b0;
      for (int k = 0; k < ROWS; k++) m_rows[k] = '0;
      return;
    end
    if (!m_run) begin
      if (en) begin
        m_run = 1'b1;
        m_pos = 0;
      end
    end else begin
      if (m_pos % S1 == S1 - 1) m_rows[m_pos / S1] = col;
      if (m_pos == FLEN - 1) begin
        fend  = 1'b1;
        m_run = en;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
    pub = 1'b0;
    if (fend) begin
      m_frames++;
      f = '0;
      for (int k = 0; k < ROWS; k++) f = (f << COLS) | 64'(m_rows[k]);
      m_cnt  = (f == m_prev) ? ((m_cnt + 1 > STABLE) ? STABLE : m_cnt + 1) : 1;
      m_prev = f;
      pub    = (m_cnt == STABLE) && ((f != m_layout) || m_first);
    end
    ld   = pub && (!m_valid || rdy);
    m_ov = pub && m_valid && !rdy;
    if (ld) begin
      m_mask   = f ^ m_layout;
      m_layout = f;
      m_valid  = 1'b1;
      m_first  = 1'b0;
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model on the edge, compare on the falling edge.
  task automatic applyStimulus(input logic en, input logic rst, input logic rdy,
                               input logic [63:0] board, input logic noise);
    logic [7:0] exp_r;
    enable       = en;
    reset        = rst;
    layout_ready = rdy;
    if (m_run && (m_pos % S1 == S1 - 1)) c = row_of(board, m_pos / S1);
    else if (noise) c = 8'($urandom);
    else c = m_run ? row_of(board, m_pos / S1) : 8'h00;
    @(posedge clk);
    model_update(en, rst, rdy, c);
    @(negedge clk);
    exp_r = m_run ? 8'(1 << (m_pos / S1)) : 8'h00;
    checkOutput("r", 64'(r), 64'(exp_r));
    checkOutput("layout_valid", 64'(layout_valid), 64'(m_valid));
    checkOutput("layout", layout, m_layout);
    checkOutput("overrun", 64'(overrun), 64'(m_ov));
`ifdef BOARD_SCANNER_CHANGE_MASK_EN
    checkOutput("change_mask", change_mask, m_mask);
`endif
  endtask

  initial begin
    logic [63:0] boards [3];
    logic [63:0] cur;
    int          first_valid;
    int          ov_seen;
    int          found;
    int          last_nz;
    int          seen_valid;
    int          lastf;
    logic        rdy;
    logic        en;

    m_frames = 0;
    $display("[TB] start");

    // Reset state
    applyStimulus(1'b0, 1'b1, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 64'h0, 1'b0);
    checkOutput("rst_r", 64'(r), 64'h0);
    checkOutput("rst_valid", 64'(layout_valid), 64'h0);
    checkOutput("rst_layout", layout, 64'h0);
    checkOutput("rst_overrun", 64'(overrun), 64'h0);

    // Row sequence and first publish at cycle 33
    first_valid = 0;
    for (int i = 1; i <= 40; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 64'hFF00_0000_0000_0000, 1'b0);
      if (i <= 16) checkOutput("r_seq", 64'(r), 64'(1 << ((i - 1) / 2)));
      if (layout_valid && first_valid == 0) first_valid = i;
    end
    checkOutput("first_valid_cycle", 64'(first_valid), 64'd33);
    checkOutput("first_layout", layout, 64'hFF00_0000_0000_0000);

    // Overrun while consumer stalls, then republish once ready
    ov_seen = 0;
    for (int i = 0; i < 3 * FLEN; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 64'h1, 1'b0);
      if (overrun) ov_seen++;
    end
    checkOutput("overrun_seen", 64'(ov_seen != 0), 64'd1);
    checkOutput("layout_held", layout, 64'hFF00_0000_0000_0000);
    found = 0;
    for (int i = 0; i < 16 && found == 0; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 64'h1, 1'b0);
      if (layout_valid && layout == 64'h1) found = 1;
    end
    checkOutput("republish_16", 64'(found), 64'd1);

    // Reset while row 3 is driven
    for (int i = 0; i < 2 * FLEN && !(m_run && m_pos / S1 == 3); i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 64'h1, 1'b0);
    checkOutput("pre_reset_r", 64'(r), 64'h08);
    applyStimulus(1'b1, 1'b1, 1'b1, 64'h1, 1'b0);
    checkOutput("midrst_r", 64'(r), 64'h0);
    checkOutput("midrst_valid", 64'(layout_valid), 64'h0);
    checkOutput("midrst_layout", layout, 64'h0);

    // Enable drop mid-frame finishes the frame then idles
    for (int i = 0; i < 2 * FLEN && !(m_run && m_pos / S1 == 2); i++)
      applyStimulus(1'b1, 1'b0, 1'b1, 64'h0, 1'b0);
    checkOutput("pre_drop_r", 64'(r), 64'h04);
    last_nz = 0;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 64'h0, 1'b0);
      if (r == 8'h00) break;
      last_nz = int'(r);
    end
    checkOutput("last_row_before_idle", 64'(last_nz), 64'h80);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 1'b0, 1'b1, 64'h0, 1'b0);
    checkOutput("idle_r", 64'(r), 64'h0);

    // Row 3 flickering every frame never becomes stable
    applyStimulus(1'b0, 1'b1, 1'b1, 64'h0, 1'b0);
    seen_valid = 0;
    m_frames   = 0;
    for (int i = 0; i < 6 * FLEN + 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1,
                    (m_frames % 2 == 0) ? 64'h0000_0001_0000_0000 : 64'h0, 1'b0);
      if (layout_valid) seen_valid = 1;
    end
    checkOutput("flicker_never_valid", 64'(seen_valid), 64'h0);

    // Randomized traffic
    for (int k = 0; k < 3; k++) boards[k] = {$urandom, $urandom};
    cur   = boards[0];
    lastf = m_frames;
    for (int i = 0; i < 3000; i++) begin
      if (m_frames != lastf) begin
        lastf = m_frames;
        if ($urandom_range(9) < 3) cur = boards[$urandom_range(2)];
      end
      en  = ($urandom_range(19) != 0);
      rdy = ($urandom_range(2) != 0);
      applyStimulus(en, ($urandom_range(999) == 0), rdy, cur, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
